// File: rtl/ipml_fifo_v1_7_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read port.
// Define IPML_FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module ipml_fifo_v1_7_sync_fifo #(
  parameter int c_DATA_WIDTH       = 32,
  parameter int c_DEPTH_WIDTH      = 9,
  parameter int c_FWFT             = 0,
  parameter int c_ALMOST_FULL_NUM  = 508,
  parameter int c_ALMOST_EMPTY_NUM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [c_DATA_WIDTH-1:0] wr_data,
  input  logic                    wr_en,
  output logic                    wr_full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [c_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_empty,
  output logic                    almost_empty,
  output logic [c_DEPTH_WIDTH:0]  water_level,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW    = c_DEPTH_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] lvl_t;

  localparam lvl_t FULL_LVL = lvl_t'(DEPTH);
  localparam lvl_t AF_LVL   = lvl_t'(c_ALMOST_FULL_NUM);
  localparam lvl_t AE_LVL   = lvl_t'(c_ALMOST_EMPTY_NUM);
  localparam logic AF_RST   = (c_ALMOST_FULL_NUM == 0);

  logic [c_DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [c_DATA_WIDTH-1:0] head;
  logic [c_DATA_WIDTH-1:0] rd_data_q, rd_data_nxt;
  lvl_t wr_ptr, wr_ptr_nxt;
  lvl_t rd_ptr, rd_ptr_nxt;
  lvl_t level, level_nxt;
  logic out_valid, out_valid_nxt;
  logic mem_load;
  logic wr_acc, rd_acc;
  logic full_q, empty_q, afull_q, aempty_q;
  logic empty_nxt;

  assign wr_acc     = wr_en & ~full_q;
  assign rd_acc     = rd_en & ~empty_q;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_acc};

  generate
    if (c_FWFT != 0) begin : g_fwft
      // The output stage counts toward the level; memory pointer moves on prefetch.
      always_comb begin
        mem_load      = (wr_ptr != rd_ptr) && (!out_valid || rd_acc);
        out_valid_nxt = mem_load || (out_valid && !rd_acc);
        rd_data_nxt   = mem_load ? head : rd_data_q;
        empty_nxt     = !out_valid_nxt;
      end
    end else begin : g_std
      always_comb begin
        mem_load      = rd_acc;
        out_valid_nxt = out_valid;
        rd_data_nxt   = rd_acc ? head : rd_data_q;
        empty_nxt     = (level_nxt == '0);
      end
    end
  endgenerate

  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, mem_load};
  assign level_nxt  = (wr_ptr_nxt - rd_ptr_nxt) + {{AW{1'b0}}, out_valid_nxt};

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      rd_data_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= AF_RST;
      aempty_q  <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      out_valid <= out_valid_nxt;
      rd_data_q <= rd_data_nxt;
      full_q    <= (level_nxt == FULL_LVL);
      empty_q   <= empty_nxt;
      afull_q   <= (level_nxt >= AF_LVL);
      aempty_q  <= (level_nxt <= AE_LVL);
    end
  end

  assign wr_full      = full_q;
  assign rd_empty     = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign water_level  = level;
  assign rd_data      = rd_data_q;

`ifdef IPML_FIFO_ERR_FLAG_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_en && full_q) ovf_q <= 1'b1;
      if (rd_en && empty_q) udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ipml_fifo_v1_7_sync_fifo.sv
// Scoreboard bench for the sync FIFO: one standard-mode and one FWFT instance,
// 16 words deep, 8 bits wide, almost thresholds 14/2.
module tb_ipml_fifo_v1_7_sync_fifo;
`ifdef IPML_FIFO_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wd_s = '0, wd_f = '0;
  logic       we_s = 1'b0, re_s = 1'b0, we_f = 1'b0, re_f = 1'b0;
  logic       full_s, af_s, empty_s, ae_s, ovf_s, udf_s;
  logic       full_f, af_f, empty_f, ae_f, ovf_f, udf_f;
  logic [7:0] rd_s, rd_f;
  logic [4:0] wl_s, wl_f;

  int tests = 0;
  int fails = 0;
  int pops_f = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];
  logic       fire_s, fire_f;
  logic [7:0] dat_f, exp_v;

  always #5 clk = ~clk;

  ipml_fifo_v1_7_sync_fifo #(
    .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(0),
    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
  ) dut_std (
    .clk(clk), .rst(rst), .wr_data(wd_s), .wr_en(we_s), .wr_full(full_s),
    .almost_full(af_s), .rd_en(re_s), .rd_data(rd_s), .rd_empty(empty_s),
    .almost_empty(ae_s), .water_level(wl_s), .overflow(ovf_s), .underflow(udf_s)
  );

  ipml_fifo_v1_7_sync_fifo #(
    .c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(1),
    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)
  ) dut_fwft (
    .clk(clk), .rst(rst), .wr_data(wd_f), .wr_en(we_f), .wr_full(full_f),
    .almost_full(af_f), .rd_en(re_f), .rd_data(rd_f), .rd_empty(empty_f),
    .almost_empty(ae_f), .water_level(wl_f), .overflow(ovf_f), .underflow(udf_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Standard-mode level plus the flags implied by it.
  task automatic chk_s(input string n, input int lvl);
    chk({n, "_level"},  32'(wl_s),    32'(lvl));
    chk({n, "_full"},   32'(full_s),  32'(lvl == 16));
    chk({n, "_empty"},  32'(empty_s), 32'(lvl == 0));
    chk({n, "_afull"},  32'(af_s),    32'(lvl >= 14));
    chk({n, "_aempty"}, 32'(ae_s),    32'(lvl <= 2));
  endtask

  // Monitor: a handshake seen at the edge pops the scoreboard.
  initial forever begin
    @(posedge clk);
    fire_s = !rst && re_s && !empty_s;
    fire_f = !rst && re_f && !empty_f;
    dat_f  = rd_f;
    if (fire_f) pops_f++;
    #1;
    if (fire_s) begin
      if (exp_s.size() == 0) begin
        tests++; fails++;
        $display("FAIL std_pop: read returned %0h, expected no word", rd_s);
      end else begin
        exp_v = exp_s.pop_front();
        chk("std_rd_data", 32'(rd_s), 32'(exp_v));
      end
    end
    if (fire_f) begin
      if (exp_f.size() == 0) begin
        tests++; fails++;
        $display("FAIL fwft_pop: popped %0h, expected no word", dat_f);
      end else begin
        exp_v = exp_f.pop_front();
        chk("fwft_rd_data", 32'(dat_f), 32'(exp_v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    chk_s("rst", 0);
    chk("rst_rd_data", 32'(rd_s), 32'h0);
    chk("rst_ovf", 32'(ovf_s), 32'h0);
    chk("rst_udf", 32'(udf_s), 32'h0);
    chk("rst_f_level", 32'(wl_f), 32'h0);
    chk("rst_f_empty", 32'(empty_f), 32'h1);
    chk("rst_f_aempty", 32'(ae_f), 32'h1);
    chk("rst_f_afull", 32'(af_f), 32'h0);
    rst = 1'b0;

    // Fill standard FIFO with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      we_s = 1'b1; wd_s = 8'(i); exp_s.push_back(8'(i));
      step();
      chk_s("fill", i + 1);
    end
    wd_s = 8'hAA;
    step();
    we_s = 1'b0;
    chk_s("drop17", 16);
    chk("drop17_ovf", 32'(ovf_s), 32'(ERR_EN));

    // Drain 16
    for (int k = 0; k < 16; k++) begin
      re_s = 1'b1;
      step();
      chk_s("drain", 15 - k);
    end
    step();
    re_s = 1'b0;
    chk_s("under", 0);
    chk("under_udf", 32'(udf_s), 32'(ERR_EN));

    // Simultaneous at empty: write wins, read ignored
    we_s = 1'b1; re_s = 1'b1; wd_s = 8'h33; exp_s.push_back(8'h33);
    step();
    re_s = 1'b0;
    chk_s("sim_empty", 1);
    for (int i = 0; i < 15; i++) begin
      wd_s = 8'(8'h34 + i); exp_s.push_back(8'(8'h34 + i));
      step();
    end
    chk_s("refill", 16);
    // Simultaneous at full: read wins, write dropped
    re_s = 1'b1; wd_s = 8'hCC;
    step();
    we_s = 1'b0;
    chk_s("sim_full", 15);
    for (int k = 0; k < 15; k++) step();
    re_s = 1'b0;
    chk_s("redrain", 0);

    // Wrap-around: level held at 4 while pointers wrap
    for (int i = 0; i < 40; i++) begin
      we_s = 1'b1; wd_s = 8'(8'h80 + i); exp_s.push_back(8'(8'h80 + i));
      re_s = (i >= 4);
      step();
      chk("wrap_level", 32'(wl_s), 32'((i < 4) ? i + 1 : 4));
      chk("wrap_full", 32'(full_s), 32'h0);
    end
    we_s = 1'b0; re_s = 1'b1;
    for (int k = 0; k < 4; k++) step();
    re_s = 1'b0;
    chk_s("wrap_end", 0);

    // FWFT: single write appears two edges later
    we_f = 1'b1; wd_f = 8'h5A; exp_f.push_back(8'h5A);
    step();
    we_f = 1'b0;
    chk("fw1_level", 32'(wl_f), 32'h1);
    chk("fw1_empty", 32'(empty_f), 32'h1);
    step();
    chk("fw2_level", 32'(wl_f), 32'h1);
    chk("fw2_empty", 32'(empty_f), 32'h0);
    chk("fw2_rd_data", 32'(rd_f), 32'h5A);
    we_f = 1'b1; wd_f = 8'h5B; exp_f.push_back(8'h5B);
    step();
    chk("fw3_level", 32'(wl_f), 32'h2);
    for (int i = 0; i < 20; i++) begin
      wd_f = 8'(8'h60 + i); exp_f.push_back(8'(8'h60 + i)); re_f = 1'b1;
      step();
      chk("fwbb_level", 32'(wl_f), 32'h2);
      chk("fwbb_empty", 32'(empty_f), 32'h0);
    end
    we_f = 1'b0;
    chk("fwbb_pops", 32'(pops_f), 32'd20);
    step();
    chk("fwdr_level1", 32'(wl_f), 32'h1);
    chk("fwdr_empty1", 32'(empty_f), 32'h0);
    step();
    chk("fwdr_level0", 32'(wl_f), 32'h0);
    chk("fwdr_empty0", 32'(empty_f), 32'h1);
    step();
    re_f = 1'b0;
    chk("fw_udf", 32'(udf_f), 32'(ERR_EN));

    // FWFT fill to full, then simultaneous at full
    we_f = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wd_f = 8'(8'hA0 + i); exp_f.push_back(8'(8'hA0 + i));
      step();
      chk("fwfill_level", 32'(wl_f), 32'(i + 1));
    end
    chk("fwfill_full", 32'(full_f), 32'h1);
    chk("fwfill_afull", 32'(af_f), 32'h1);
    re_f = 1'b1; wd_f = 8'hDD;
    step();
    we_f = 1'b0;
    chk("fwsim_level", 32'(wl_f), 32'd15);
    chk("fwsim_full", 32'(full_f), 32'h0);
    chk("fwsim_ovf", 32'(ovf_f), 32'(ERR_EN));
    for (int k = 0; k < 15; k++) step();
    re_f = 1'b0;
    chk("fwend_level", 32'(wl_f), 32'h0);
    chk("fwend_empty", 32'(empty_f), 32'h1);

    // Reset mid-operation at level 9 with a concurrent write
    we_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wd_s = 8'(8'h90 + i);
      step();
    end
    chk("pre_rst_level", 32'(wl_s), 32'd9);
    rst = 1'b1; wd_s = 8'hEE;
    step();
    rst = 1'b0; we_s = 1'b0;
    chk_s("midrst", 0);
    chk("midrst_ovf", 32'(ovf_s), 32'h0);
    chk("midrst_udf", 32'(udf_s), 32'h0);
    chk("midrst_f_ovf", 32'(ovf_f), 32'h0);
    chk("midrst_f_udf", 32'(udf_f), 32'h0);
    step();
    chk_s("postrst", 0);
    we_s = 1'b1; wd_s = 8'h77; exp_s.push_back(8'h77);
    step();
    we_s = 1'b0;
    chk_s("postrst_wr", 1);
    re_s = 1'b1;
    step();
    re_s = 1'b0;
    chk_s("postrst_rd", 0);
    step();

    chk("std_leftover", 32'(exp_s.size()), 32'h0);
    chk("fwft_leftover", 32'(exp_f.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
